alu4_seq: RTL

ALU4_SEQ -- requirements
Module: alu4_seq

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu4_slice.sv | 52 +++++
 rtl/alu4_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU: function codes and sequencer states.
package alu_seq_pkg;

    localparam logic [2:0] FN_ADD   = 3'd0;
    localparam logic [2:0] FN_AND   = 3'd1;
    localparam logic [2:0] FN_OR    = 3'd2;
    localparam logic [2:0] FN_XOR   = 3'd3;
    localparam logic [2:0] FN_PASSA = 3'd4;
    localparam logic [2:0] FN_PASSB = 3'd5;
    localparam logic [2:0] FN_SHR   = 3'd6;
    localparam logic [2:0] FN_SHL   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu4_slice.sv
// Combinational 4-bit ALU slice. Left carry flows toward the MSB (ADD/SHL),
// right carry flows toward the LSB (SHR). Inversion is applied after the
// function, and the zero/all-ones flags look at the inverted value.
module alu4_slice
    import alu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] func,
    input  logic       com,
    input  logic       ci_left,
    input  logic       ci_right,
    output logic [3:0] d,
    output logic       co_left,
    output logic       co_right,
    output logic       zero,
    output logic       neg_zero,
    output logic       equ
);

    logic [3:0] raw;

    // Nibble function and carry generation
    always_comb begin
        raw      = 4'h0;
        co_left  = 1'b0;
        co_right = 1'b0;
        case (func)
            FN_ADD:   {co_left, raw} = 5'(a) + 5'(b) + 5'(ci_right);
            FN_AND:   raw = a & b;
            FN_OR:    raw = a | b;
            FN_XOR:   raw = a ^ b;
            FN_PASSA: raw = a;
            FN_PASSB: raw = b;
            FN_SHR: begin
                raw      = {ci_left, a[3:1]};
                co_right = a[0];
            end
            FN_SHL: begin
                raw     = {a[2:0], ci_right};
                co_left = a[3];
            end
            default:  raw = 4'h0;
        endcase
    end

    assign d        = com ? ~raw : raw;
    assign zero     = (d == 4'h0);
    assign neg_zero = (d == 4'hF);
    assign equ      = (a == b);

endmodule

// File: rtl/alu4_seq.sv
// Nibble-serial ALU: one shared 4-bit slice walks the operands one nibble per
// cycle (MS nibble first for SHR, LS nibble first otherwise), chaining the
// carry through a register and AND-accumulating the per-nibble flags.
module alu4_seq
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic [2:0]           func,
    input  logic                 com,
    input  logic                 ci,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 co,
    output logic                 zero,
    output logic                 neg_zero,
    output logic                 equ
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_lat;
    logic [W-1:0]  b_lat;
    logic [2:0]    func_lat;
    logic          com_lat;
    logic          carry;
    logic [W-1:0]  work;
    logic          z_acc;
    logic          nz_acc;
    logic          eq_acc;

    logic [CW-1:0] idx;
    logic [CW+1:0] base;
    logic [3:0]    s_a;
    logic [3:0]    s_b;
    logic [3:0]    s_d;
    logic          s_co_left;
    logic          s_co_right;
    logic          s_zero;
    logic          s_neg_zero;
    logic          s_equ;
    logic          carry_nxt;
    logic [W-1:0]  work_nxt;

    assign idx  = (func_lat == FN_SHR) ? (LAST - cnt) : cnt;
    assign base = {idx, 2'b00};
    assign s_a  = a_lat[base +: 4];
    assign s_b  = b_lat[base +: 4];

    // Unused carry direction is zero from the slice, so one register serves both
    assign carry_nxt = (func_lat == FN_SHR) ? s_co_right : s_co_left;

    alu4_slice u_slice (
        .a        (s_a),
        .b        (s_b),
        .func     (func_lat),
        .com      (com_lat),
        .ci_left  (carry),
        .ci_right (carry),
        .d        (s_d),
        .co_left  (s_co_left),
        .co_right (s_co_right),
        .zero     (s_zero),
        .neg_zero (s_neg_zero),
        .equ      (s_equ)
    );

    // Merge the current nibble into the partial result
    always_comb begin
        work_nxt            = work;
        work_nxt[base +: 4] = s_d;
    end

    // Sequencer: accept, run NIBBLES slice steps, then present a one-cycle done
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            co       <= 1'b0;
            zero     <= 1'b0;
            neg_zero <= 1'b0;
            equ      <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= ST_RUN;
                        busy     <= 1'b1;
                        a_lat    <= op_a;
                        b_lat    <= op_b;
                        func_lat <= func;
                        com_lat  <= com;
                        carry    <= ci;
                        cnt      <= '0;
                        z_acc    <= 1'b1;
                        nz_acc   <= 1'b1;
                        eq_acc   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    work   <= work_nxt;
                    carry  <= carry_nxt;
                    z_acc  <= z_acc & s_zero;
                    nz_acc <= nz_acc & s_neg_zero;
                    eq_acc <= eq_acc & s_equ;
                    if (cnt == LAST) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cnt      <= '0;
                        result   <= work_nxt;
                        co       <= carry_nxt;
                        zero     <= z_acc & s_zero;
                        neg_zero <= nz_acc & s_neg_zero;
                        equ      <= eq_acc & s_equ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
